alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle successor to the single-cycle CPU ALU. It keeps the existing opcode map and flag semantics and adds registered outputs, a start/done handshake, and iterative signed MULT and DIV. It sits in the EX stage; the pipeline stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits (even, >= 8)
OPW, 6, opcode width
SHW, $clog2(WIDTH), shift-amount bits taken from in2[SHW-1:0]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch operation; sampled only when busy=0
opcode  in  OPW  operation select, latched at start
alu_in1  in  WIDTH  operand A (rs / $d), latched at start
alu_in2  in  WIDTH  operand B (rt / imm / shamt), latched at start
alu_out  out  WIDTH  registered result, held until next done
busy  out  1  operation in progress
done  out  1  one-cycle pulse when alu_out and flags are updated
n_flag  out  1  negative flag, registered
z_flag  out  1  zero flag, registered
v_flag  out  1  overflow flag, registered

Behaviour:
- Reset (async assert, sync release): alu_out=0, n/z/v=0, busy=0, done=0, FSM=IDLE. Assertion mid-operation aborts the operation immediately with no done.
- Opcodes: ADD 00, ADDI 01, SUB 02, AND 03, ANDI 04, SLL 05, SRL 06, DIV 15, MULT 16, NAND 22, XOR 23, NO_OP 3F. Unlisted opcodes behave as NO_OP.
- FSM states: IDLE, EXEC1, MUL_ITER, DIV_ITER, FIX, DONE.
- IDLE + start: latch operands. MULT goes to MUL_ITER, DIV goes to DIV_ITER, everything else goes to EXEC1.
- EXEC1: compute the result and go to DONE. Single-cycle latency is start at cycle t, done at t+2 (t+1 EXEC1, t+2 DONE pulse).
- MUL_ITER: unsigned shift-add on operand magnitudes, WIDTH iterations, then FIX.
- DIV_ITER: restoring division on magnitudes, WIDTH iterations, then FIX.
- FIX: apply the result sign (MULT: sign A ^ sign B; DIV quotient: sign A ^ sign B, truncation toward zero), then DONE. MULT/DIV latency is WIDTH+3 cycles from start to done.
- DONE: pulse done, write alu_out and flags, return to IDLE. busy is 1 in every state except IDLE.
- start while busy=1 is ignored; no queueing.
- Arithmetic: ADD/ADDI/SUB are modulo 2^WIDTH. V is signed overflow (carry into MSB XOR carry out). ADDI is identical to ADD; ANDI is identical to AND.
- Logic ops AND/NAND/XOR: V=0.
- N = alu_out[WIDTH-1]; Z = (alu_out==0). Both are updated for every op except SLL, SRL and NO_OP.
- SLL/SRL: shift is logical by in2[SHW-1:0]. alu_out is updated; flags are unchanged.
- NO_OP: done still pulses; alu_out and flags are unchanged.
- MULT: alu_out = low WIDTH bits of the signed product. V=1 if the 2*WIDTH product is not the sign-extension of alu_out.
- DIV: alu_out = signed quotient. Divisor 0 gives alu_out = all ones and V=1 (no iteration; DIV_ITER is skipped). Most-negative / -1 gives alu_out = most-negative and V=1.

Optional Feature:
ALU_DIV_EN:
- Defined: DIV is implemented as above.
- Undefined: no divider datapath is built. Opcode 15 is treated as NO_OP (done at t+2, output and flags unchanged).

Decomposition:
- Package alu_pkg: opcode localparams (ADD..NO_OP) and the FSM state enum.
- One sub-module, alu_muldiv_iter: the shared magnitude shift-add / restoring-divide datapath with an iteration counter. It is reused for both MULT and DIV.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> alu_out 0x80000000, N=1 Z=0 V=1, done at t+2.
- SUB 5 - 5 -> alu_out 0, Z=1 N=0 V=0. Then SLL 0x1, in2=0x21 (shamt 1) -> alu_out 2, flags still Z=1.
- MULT -3 x 7 -> alu_out 0xFFFFFFEB, N=1 V=0, done at t+35. MULT 0x00010000 x 0x00010000 -> alu_out 0, V=1.
- DIV -7 / 2 -> alu_out 0xFFFFFFFD. DIV 9 / 0 -> alu_out 0xFFFFFFFF, V=1. With ALU_DIV_EN undefined, DIV leaves prior state unchanged.
- start pulsed during a MULT busy window -> ignored; only one done, result from the first op.
- rst_n low mid-MULT -> busy=0, done never pulses, all outputs 0. A following ADD 1+2 -> alu_out 3.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map and FSM state encoding for the multi-cycle ALU
package alu_pkg;

  // Opcode map inherited from the single-cycle ALU
  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_SUB   = 6'h02;
  localparam logic [5:0] OP_AND   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h04;
  localparam logic [5:0] OP_SLL   = 6'h05;
  localparam logic [5:0] OP_SRL   = 6'h06;
  localparam logic [5:0] OP_DIV   = 6'h15;
  localparam logic [5:0] OP_MULT  = 6'h16;
  localparam logic [5:0] OP_NAND  = 6'h22;
  localparam logic [5:0] OP_XOR   = 6'h23;
  localparam logic [5:0] OP_NO_OP = 6'h3F;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_EXEC1    = 3'd1,
    S_MUL_ITER = 3'd2,
    S_DIV_ITER = 3'd3,
    S_FIX      = 3'd4,
    S_DONE     = 3'd5
  } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - shared magnitude shift-add multiply / restoring divide; divide path built only with ALU_DIV_EN
module alu_muldiv_iter #(
  parameter int WIDTH = 32
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // r_hi: product upper half (MULT) or partial remainder (DIV)
  // r_lo: multiplier shifting out / product lower half (MULT) or dividend -> quotient (DIV)
  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic [CW-1:0]    r_cnt;
  logic             r_run, r_done;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt;

`ifdef ALU_DIV_EN
  logic             r_is_div;
  logic [WIDTH:0]   w_shift, w_diff;
`else
  logic             w_unused_div;
  assign w_unused_div = i_is_div;
`endif

  // Next-state of one iteration step for whichever operation is running
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_hi_nxt = w_sum[WIDTH:1];
    w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    w_shift  = {r_hi, r_lo[WIDTH-1]};
    w_diff   = w_shift - {1'b0, r_b};
    if (r_is_div) begin
      // Negative trial difference (MSB set) means restore the shifted remainder
      w_hi_nxt = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    end
`endif
  end

  // Load on start, then run exactly WIDTH steps and pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
`ifdef ALU_DIV_EN
      r_is_div <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_hi  <= '0;
        r_lo  <= i_a;
        r_b   <= i_b;
        r_cnt <= '0;
        r_run <= 1'b1;
`ifdef ALU_DIV_EN
        r_is_div <= i_is_div;
`endif
      end else if (r_run) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle EX-stage ALU with start/done handshake; signed DIV built only with ALU_DIV_EN
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 6,
  parameter int SHW   = $clog2(WIDTH)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   opcode,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic             n_flag,
  output logic             z_flag,
  output logic             v_flag
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_e       r_state;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_v, r_wr_out, r_wr_flags;

  logic             w_is_mult, w_is_div, w_it_start, w_it_done;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_it_hi, w_it_lo;
  logic [WIDTH-1:0] w_exec_res;
  logic             w_exec_v, w_exec_wr_out, w_exec_wr_flags;
  logic             w_neg;
  logic [2*WIDTH-1:0] w_prod_mag, w_prod;
  logic [WIDTH-1:0] w_fix_res;
  logic             w_fix_v;

  assign w_is_mult = (opcode == OPW'(OP_MULT));
`ifdef ALU_DIV_EN
  assign w_is_div  = (opcode == OPW'(OP_DIV));
`else
  assign w_is_div  = 1'b0;
`endif

  // The iterator loads magnitudes on the start edge, straight from the ports
  assign w_a_mag    = alu_in1[WIDTH-1] ? -alu_in1 : alu_in1;
  assign w_b_mag    = alu_in2[WIDTH-1] ? -alu_in2 : alu_in2;
  assign w_it_start = (r_state == S_IDLE) && start &&
                      (w_is_mult || (w_is_div && (alu_in2 != '0)));

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_it_start),
    .i_is_div (w_is_div),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_done   (w_it_done),
    .o_hi     (w_it_hi),
    .o_lo     (w_it_lo)
  );

  // Single-cycle ops: result, overflow and which outputs the op is allowed to touch
  always_comb begin
    w_exec_res      = '0;
    w_exec_v        = 1'b0;
    w_exec_wr_out   = 1'b0;
    w_exec_wr_flags = 1'b0;
    case (r_op)
      OPW'(OP_ADD), OPW'(OP_ADDI): begin
        w_exec_res      = r_a + r_b;
        w_exec_v        = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_exec_res[WIDTH-1] != r_a[WIDTH-1]);
        w_exec_wr_out   = 1'b1;
        w_exec_wr_flags = 1'b1;
      end
      OPW'(OP_SUB): begin
        w_exec_res      = r_a - r_b;
        w_exec_v        = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_exec_res[WIDTH-1] != r_a[WIDTH-1]);
        w_exec_wr_out   = 1'b1;
        w_exec_wr_flags = 1'b1;
      end
      OPW'(OP_AND), OPW'(OP_ANDI): begin
        w_exec_res      = r_a & r_b;
        w_exec_wr_out   = 1'b1;
        w_exec_wr_flags = 1'b1;
      end
      OPW'(OP_NAND): begin
        w_exec_res      = ~(r_a & r_b);
        w_exec_wr_out   = 1'b1;
        w_exec_wr_flags = 1'b1;
      end
      OPW'(OP_XOR): begin
        w_exec_res      = r_a ^ r_b;
        w_exec_wr_out   = 1'b1;
        w_exec_wr_flags = 1'b1;
      end
      OPW'(OP_SLL): begin
        w_exec_res    = r_a << r_b[SHW-1:0];
        w_exec_wr_out = 1'b1;
      end
      OPW'(OP_SRL): begin
        w_exec_res    = r_a >> r_b[SHW-1:0];
        w_exec_wr_out = 1'b1;
      end
      default: ;
    endcase
  end

  // Sign fix-up of the magnitude result from the iterator
  always_comb begin
    w_neg      = r_a[WIDTH-1] ^ r_b[WIDTH-1];
    w_prod_mag = {w_it_hi, w_it_lo};
    w_prod     = w_neg ? -w_prod_mag : w_prod_mag;
    w_fix_res  = w_prod[WIDTH-1:0];
    w_fix_v    = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
`ifdef ALU_DIV_EN
    if (r_op == OPW'(OP_DIV)) begin
      if (r_b == '0) begin
        w_fix_res = '1;
        w_fix_v   = 1'b1;
      end else begin
        w_fix_res = w_neg ? -w_it_lo : w_it_lo;
        w_fix_v   = (r_a == MOST_NEG) && (r_b == '1);
      end
    end
`endif
  end

  // Control FSM with registered handshake, result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_v        <= 1'b0;
      r_wr_out   <= 1'b0;
      r_wr_flags <= 1'b0;
      alu_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      n_flag     <= 1'b0;
      z_flag     <= 1'b0;
      v_flag     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op <= opcode;
            r_a  <= alu_in1;
            r_b  <= alu_in2;
            busy <= 1'b1;
            if (w_is_mult)
              r_state <= S_MUL_ITER;
            else if (w_is_div)
              r_state <= (alu_in2 == '0) ? S_FIX : S_DIV_ITER;
            else
              r_state <= S_EXEC1;
          end
        end
        S_EXEC1: begin
          r_res      <= w_exec_res;
          r_v        <= w_exec_v;
          r_wr_out   <= w_exec_wr_out;
          r_wr_flags <= w_exec_wr_flags;
          r_state    <= S_DONE;
        end
        S_MUL_ITER, S_DIV_ITER: begin
          if (w_it_done)
            r_state <= S_FIX;
        end
        S_FIX: begin
          r_res      <= w_fix_res;
          r_v        <= w_fix_v;
          r_wr_out   <= 1'b1;
          r_wr_flags <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          if (r_wr_out)
            alu_out <= r_res;
          if (r_wr_flags) begin
            n_flag <= r_res[WIDTH-1];
            z_flag <= (r_res == '0);
            v_flag <= r_v;
          end
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc; models DIV when ALU_DIV_EN is defined
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] alu_in1 = '0;
  logic [31:0] alu_in2 = '0;
  logic [31:0] alu_out;
  logic        busy, done, n_flag, z_flag, v_flag;

  alu_mc #(.WIDTH(32), .OPW(6)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .opcode  (opcode),
    .alu_in1 (alu_in1),
    .alu_in2 (alu_in2),
    .alu_out (alu_out),
    .busy    (busy),
    .done    (done),
    .n_flag  (n_flag),
    .z_flag  (z_flag),
    .v_flag  (v_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] out;
    logic        n;
    logic        z;
    logic        v;
    logic [15:0] lat;
    logic [31:0] t0;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [31:0] m_out = '0;
  logic        m_n = 1'b0, m_z = 1'b0, m_v = 1'b0;
  int          n_checks = 0, n_pass = 0;
  int          done_cnt = 0, issue_cnt = 0;
  logic [5:0]  ops [0:12];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference behaviour using wide signed arithmetic
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [15:0] lat);
    longint      s;
    logic [31:0] r;
    logic        v, upd_out, upd_fl;
    lat = 16'd2; r = m_out; v = 1'b0; upd_out = 1'b0; upd_fl = 1'b0;
    case (op)
      6'h00, 6'h01: begin
        s = longint'($signed(a)) + longint'($signed(b)); r = s[31:0];
        v = (s != longint'($signed(r))); upd_out = 1'b1; upd_fl = 1'b1;
      end
      6'h02: begin
        s = longint'($signed(a)) - longint'($signed(b)); r = s[31:0];
        v = (s != longint'($signed(r))); upd_out = 1'b1; upd_fl = 1'b1;
      end
      6'h03, 6'h04: begin r = a & b;    upd_out = 1'b1; upd_fl = 1'b1; end
      6'h22:        begin r = ~(a & b); upd_out = 1'b1; upd_fl = 1'b1; end
      6'h23:        begin r = a ^ b;    upd_out = 1'b1; upd_fl = 1'b1; end
      6'h05:        begin r = a << b[4:0]; upd_out = 1'b1; end
      6'h06:        begin r = a >> b[4:0]; upd_out = 1'b1; end
      6'h16: begin
        s = longint'($signed(a)) * longint'($signed(b)); r = s[31:0];
        v = (s != longint'($signed(r))); lat = 16'd35; upd_out = 1'b1; upd_fl = 1'b1;
      end
      6'h15: begin
`ifdef ALU_DIV_EN
        upd_out = 1'b1; upd_fl = 1'b1;
        if (b == 32'd0) begin
          r = 32'hFFFF_FFFF; v = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = 32'h8000_0000; v = 1'b1; lat = 16'd35;
        end else begin
          r = $signed(a) / $signed(b); lat = 16'd35;
        end
`endif
      end
      default: ;
    endcase
    if (upd_out) m_out = r;
    if (upd_fl) begin m_n = r[31]; m_z = (r == 32'd0); m_v = v; end
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        x;
    logic [15:0] lat;
    int          k;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin @(negedge clk); k++; end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
    opcode = op; alu_in1 = a; alu_in2 = b; start = 1'b1;
    model(op, a, b, lat);
    x.out = m_out; x.n = m_n; x.z = m_z; x.v = m_v; x.lat = lat; x.t0 = 32'(cyc + 1);
    sb.push_back(x);
    issue_cnt++;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 500) begin @(negedge clk); k++; end
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Pop and compare on every done pulse
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("alu_out", {32'd0, alu_out}, {32'd0, e.out});
        check("n_flag", {63'd0, n_flag}, {63'd0, e.n});
        check("z_flag", {63'd0, z_flag}, {63'd0, e.z});
        check("v_flag", {63'd0, v_flag}, {63'd0, e.v});
        check("latency", 64'(cyc - int'(e.t0)), {48'd0, e.lat});
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  initial begin
    ops[0] = 6'h00; ops[1] = 6'h01; ops[2] = 6'h02; ops[3] = 6'h03; ops[4] = 6'h04;
    ops[5] = 6'h05; ops[6] = 6'h06; ops[7] = 6'h15; ops[8] = 6'h16; ops[9] = 6'h22;
    ops[10] = 6'h23; ops[11] = 6'h3F; ops[12] = 6'h2A;

    repeat (3) @(negedge clk);
    check("rst_alu_out", {32'd0, alu_out}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_flags", {61'd0, n_flag, z_flag, v_flag}, 64'd0);
    rst_n = 1'b1;

    // Directed cases
    issue(6'h00, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(6'h02, 32'd5, 32'd5);
    issue(6'h05, 32'h1, 32'h21);
    issue(6'h16, 32'hFFFF_FFFD, 32'd7);
    issue(6'h16, 32'h0001_0000, 32'h0001_0000);
    issue(6'h15, 32'hFFFF_FFF9, 32'd2);
    issue(6'h15, 32'd9, 32'd0);
    issue(6'h15, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(6'h3F, 32'h1234, 32'h5678);
    drain();

    // Randomised mix of every opcode plus an unlisted one
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      int sa, sbv;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        sa = int'($urandom_range(0, 40)) - 20; sbv = int'($urandom_range(0, 8)) - 4;
        a = 32'(sa); b = 32'(sbv);
      end
      issue(ops[$urandom_range(0, 12)], a, b);
    end
    drain();

    // start pulsed inside a MULT busy window must be ignored
    issue(6'h16, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    opcode = 6'h00; alu_in1 = 32'd1; alu_in2 = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a MULT
    issue(6'h00, 32'h7FFF_FFFF, 32'h0000_0001);
    issue(6'h16, 32'hFFFF_FFFD, 32'd7);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_alu_out", {32'd0, alu_out}, 64'd0);
    check("abort_flags", {61'd0, n_flag, z_flag, v_flag}, 64'd0);
    sb.delete();
    issue_cnt--;
    m_out = '0; m_n = 1'b0; m_z = 1'b0; m_v = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(6'h00, 32'd1, 32'd2);
    drain();
    repeat (5) @(negedge clk);
    check("done_count", 64'(done_cnt), 64'(issue_cnt));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
